// File: rtl/priority_decoder_2to4.sv
// priority_decoder_2to4: FIFO-buffered registered 2-to-4 decoder for {any, code} entries
// with per-line saturating delivery counters.
module priority_decoder_2to4 #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    input  logic             in_any,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_onehot,
    input  logic             cnt_clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [2:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] cnt [4];
    logic             full, empty, push, pop, head_any;
    logic [1:0]       head_code;
    always_comb begin
        full       = count == CW'(FIFO_DEPTH);
        empty      = count == '0;
        in_ready   = !full;
        out_valid  = !empty;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        head_any   = mem[rd_ptr][2];
        head_code  = mem[rd_ptr][1:0];
        out_onehot = (!empty && head_any) ? 4'(1) << head_code : 4'b0000;
        cnt_val    = cnt[cnt_sel];
    end
    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_any, in_code};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (pop && head_any && cnt[head_code] != {CNT_W{1'b1}}) begin
            cnt[head_code] <= cnt[head_code] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_priority_decoder_2to4.sv
// tb_priority_decoder_2to4: directed checks of decode, handshake, backpressure,
// counter saturation/clear and asynchronous reset.
module tb_priority_decoder_2to4;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, in_any, out_valid, out_ready, cnt_clr;
    logic [1:0] in_code, cnt_sel;
    logic [3:0] out_onehot;
    logic [7:0] cnt_val;
    int         tests = 0;
    int         fails = 0;

    priority_decoder_2to4 #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_any(in_any), .out_valid(out_valid),
        .out_ready(out_ready), .out_onehot(out_onehot), .cnt_clr(cnt_clr),
        .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        cnt_sel = sel;
        #1;
        check(tag, cnt_val, exp);
    endtask

    task automatic set_in(input logic v, input logic [1:0] c, input logic a);
        in_valid = v;
        in_code  = c;
        in_any   = a;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; cnt_sel = 2'd0;
        set_in(1'b0, 2'd0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_onehot", out_onehot, 4'b0000);
        for (int s = 0; s < 4; s++) check_cnt("rst_cnt", 2'(s), 8'd0);

        // back-to-back decode of all four codes
        out_ready = 1'b1;
        set_in(1'b1, 2'd0, 1'b1); tick();
        check("dec0_valid", out_valid, 1);
        check("dec0", out_onehot, 4'b0001);
        set_in(1'b1, 2'd1, 1'b1); tick();
        check("dec1", out_onehot, 4'b0010);
        set_in(1'b1, 2'd2, 1'b1); tick();
        check("dec2", out_onehot, 4'b0100);
        set_in(1'b1, 2'd3, 1'b1); tick();
        check("dec3", out_onehot, 4'b1000);
        set_in(1'b0, 2'd0, 1'b0); tick();
        check("drain_valid", out_valid, 0);
        check("drain_onehot", out_onehot, 4'b0000);
        for (int s = 0; s < 4; s++) check_cnt("cnt_after_dec", 2'(s), 8'd1);

        // in_any=0 entry: real entry, no lines, no count
        set_in(1'b1, 2'd2, 1'b0); tick();
        set_in(1'b0, 2'd0, 1'b0);
        check("none_valid", out_valid, 1);
        check("none_onehot", out_onehot, 4'b0000);
        tick();
        check("none_drained", out_valid, 0);
        check_cnt("none_cnt2", 2'd2, 8'd1);

        // backpressure with a depth-2 FIFO
        out_ready = 1'b0;
        set_in(1'b1, 2'd3, 1'b1); tick();
        check("bp_ready1", in_ready, 1);
        set_in(1'b1, 2'd1, 1'b1); tick();
        check("bp_full", in_ready, 0);
        check("bp_hold", out_onehot, 4'b1000);
        set_in(1'b1, 2'd0, 1'b1); tick();
        check("bp_reject_ready", in_ready, 0);
        check("bp_hold2", out_onehot, 4'b1000);
        set_in(1'b0, 2'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("bp_pop1", out_onehot, 4'b0010);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_pop2_empty", out_valid, 0);
        tick();
        check("bp_no_extra", out_valid, 0);
        check_cnt("bp_cnt3", 2'd3, 8'd2);
        check_cnt("bp_cnt1", 2'd1, 8'd2);
        check_cnt("bp_cnt0", 2'd0, 8'd1);

        // saturation: 300 more code-1 pops on top of 2 already counted
        set_in(1'b1, 2'd1, 1'b1);
        repeat (300) tick();
        set_in(1'b0, 2'd0, 1'b0);
        tick();
        check("sat_empty", out_valid, 0);
        check_cnt("sat_cnt1", 2'd1, 8'd255);
        check_cnt("sat_cnt0", 2'd0, 8'd1);

        // clear beats a same-cycle increment
        set_in(1'b1, 2'd1, 1'b1); tick();
        set_in(1'b0, 2'd0, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_empty", out_valid, 0);
        check_cnt("clr_cnt1", 2'd1, 8'd0);
        check_cnt("clr_cnt0", 2'd0, 8'd0);
        check_cnt("clr_cnt3", 2'd3, 8'd0);
        set_in(1'b1, 2'd1, 1'b1); tick();
        set_in(1'b0, 2'd0, 1'b0); tick();
        check_cnt("post_clr_cnt1", 2'd1, 8'd1);

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        set_in(1'b1, 2'd2, 1'b1); tick();
        set_in(1'b1, 2'd0, 1'b1); tick();
        set_in(1'b0, 2'd0, 1'b0);
        check("pre_rst_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_onehot", out_onehot, 4'b0000);
        check_cnt("arst_cnt1", 2'd1, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_no_stale", out_valid, 0);
        tick();
        check("post_rst_no_stale2", out_valid, 0);
        check("post_rst_onehot", out_onehot, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
